// File: rtl/de0_board_io_cond.sv
// Input conditioning for DE0 buttons and switches: 2-flop sync, debounce, edge strobes,
// and a stretched system reset driven by one of the buttons.
module de0_board_io_cond #(
  parameter int unsigned N_BTN      = 3,
  parameter int unsigned N_SW       = 10,
  parameter int unsigned DEB_CYCLES = 50000,
  parameter int unsigned RST_BTN    = 0,
  parameter int unsigned RST_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_SW-1:0]  sw_in,
  output logic [N_BTN-1:0] btn_prs,
  output logic [N_BTN-1:0] btn_dn,
  output logic [N_BTN-1:0] btn_up,
  output logic [N_SW-1:0]  sw_lvl,
  output logic             sw_chg,
  output logic             sys_rst_n
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned RW = $clog2(RST_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {HOLD, COUNT, RUN} rst_state_t;

  logic [N_BTN-1:0] btn_s1, btn_s2, btn_d, btn_upd;
  logic [CW-1:0]    btn_cnt [N_BTN];
  logic [N_SW-1:0]  sw_s1, sw_s2, sw_d, sw_upd;
  logic [CW-1:0]    sw_cnt [N_SW];

  rst_state_t state, state_next;
  logic [RW-1:0] rcnt, rcnt_next;

  // A channel accepts its synced level once it has differed from d for DEB_CYCLES clocks.
  always_comb begin
    btn_upd = '0;
    for (int unsigned i = 0; i < N_BTN; i++)
      btn_upd[i] = (btn_s2[i] != btn_d[i]) && (btn_cnt[i] == DEB_LAST);
    sw_upd = '0;
    for (int unsigned i = 0; i < N_SW; i++)
      sw_upd[i] = (sw_s2[i] != sw_d[i]) && (sw_cnt[i] == DEB_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1 <= '1;
      btn_s2 <= '1;
      btn_d  <= '1;
      btn_dn <= '0;
      btn_up <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) btn_cnt[i] <= '0;
    end else begin
      btn_s1 <= btn_in;
      btn_s2 <= btn_s1;
      btn_d  <= btn_d ^ btn_upd;
      btn_dn <= btn_upd & ~btn_s2;
      btn_up <= btn_upd & btn_s2;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if ((btn_s2[i] == btn_d[i]) || btn_upd[i]) btn_cnt[i] <= '0;
        else                                       btn_cnt[i] <= btn_cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      sw_d   <= '0;
      sw_chg <= 1'b0;
      for (int unsigned i = 0; i < N_SW; i++) sw_cnt[i] <= '0;
    end else begin
      sw_s1  <= sw_in;
      sw_s2  <= sw_s1;
      sw_d   <= sw_d ^ sw_upd;
      sw_chg <= |sw_upd;
      for (int unsigned i = 0; i < N_SW; i++) begin
        if ((sw_s2[i] == sw_d[i]) || sw_upd[i]) sw_cnt[i] <= '0;
        else                                    sw_cnt[i] <= sw_cnt[i] + CW'(1);
      end
    end
  end

  assign btn_prs = ~btn_d;
  assign sw_lvl  = sw_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HOLD;
      rcnt  <= '0;
    end else begin
      state <= state_next;
      rcnt  <= rcnt_next;
    end
  end

  always_comb begin
    state_next = state;
    rcnt_next  = rcnt;
    if (btn_prs[RST_BTN]) begin
      state_next = HOLD;
      rcnt_next  = '0;
    end else begin
      unique case (state)
        HOLD: begin
          state_next = COUNT;
          rcnt_next  = '0;
        end
        COUNT: begin
          if (rcnt == RST_LAST) begin
            state_next = RUN;
            rcnt_next  = '0;
          end else begin
            rcnt_next = rcnt + RW'(1);
          end
        end
        RUN: ;
        default: begin
          state_next = HOLD;
          rcnt_next  = '0;
        end
      endcase
    end
  end

  // Gating with the debounced button drops the reset in the same cycle the press is accepted,
  // one clock ahead of the FSM leaving RUN; deassertion still only follows the registered state.
  assign sys_rst_n = (state == RUN) && !btn_prs[RST_BTN];

endmodule

// File: tb/tb_de0_board_io_cond.sv
// Directed bench for de0_board_io_cond with short debounce and reset-stretch settings.
module tb_de0_board_io_cond;

  logic       clk;
  logic       rst_n;
  logic [2:0] btn_in;
  logic [9:0] sw_in;
  logic [2:0] btn_prs, btn_dn, btn_up;
  logic [9:0] sw_lvl;
  logic       sw_chg;
  logic       sys_rst_n;

  int checks = 0;
  int errors = 0;

  de0_board_io_cond #(
    .N_BTN(3),
    .N_SW(10),
    .DEB_CYCLES(4),
    .RST_BTN(0),
    .RST_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_in(btn_in),
    .sw_in(sw_in),
    .btn_prs(btn_prs),
    .btn_dn(btn_dn),
    .btn_up(btn_up),
    .sw_lvl(sw_lvl),
    .sw_chg(sw_chg),
    .sys_rst_n(sys_rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  btn;
    logic [9:0]  sw;
    int unsigned ticks;
    logic [2:0]  prs;
    logic [9:0]  lvl;
    logic        rst;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{3'b111, 10'h155, 8, 3'b000, 10'h155, 1'b1};
    vecs[1] = '{3'b101, 10'h155, 8, 3'b010, 10'h155, 1'b1};
    vecs[2] = '{3'b001, 10'h2AA, 8, 3'b110, 10'h2AA, 1'b1};
    vecs[3] = '{3'b011, 10'h3FF, 8, 3'b100, 10'h3FF, 1'b1};
    vecs[4] = '{3'b111, 10'h000, 8, 3'b000, 10'h000, 1'b1};
    vecs[5] = '{3'b111, 10'h200, 8, 3'b000, 10'h200, 1'b1};

    rst_n  = 1'b0;
    btn_in = 3'b111;
    sw_in  = '0;
    #200;
    check("rst_prs", btn_prs, 0);
    check("rst_lvl", sw_lvl, 0);
    check("rst_strobes", {btn_dn, btn_up, sw_chg}, 0);
    check("rst_sys", sys_rst_n, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset stretch: low through 8 edges after release, high on the 9th
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("t1_sys", sys_rst_n, (i == 9));
      check("t1_prs", btn_prs, 0);
      check("t1_strobes", {btn_dn, btn_up, sw_chg}, 0);
    end

    // Press and release latency on btn[1]
    btn_in = 3'b101;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("t2_prs", btn_prs[1], (i >= 6));
      check("t2_dn", btn_dn, (i == 6) ? 3'b010 : 3'b000);
      check("t2_up", btn_up, 0);
    end
    btn_in = 3'b111;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("t2r_prs", btn_prs[1], (i < 6));
      check("t2r_up", btn_up, (i == 6) ? 3'b010 : 3'b000);
      check("t2r_dn", btn_dn, 0);
    end

    // 3-clock glitch on btn[2] is rejected
    btn_in = 3'b011;
    for (int i = 1; i <= 10; i++) begin
      if (i == 4) btn_in = 3'b111;
      tick();
      check("t3_prs", btn_prs[2], 0);
      check("t3_dn", btn_dn, 0);
    end
    // Counter restarted: a held press takes the full latency again
    btn_in = 3'b011;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("t3b_prs", btn_prs[2], (i == 6));
    end
    btn_in = 3'b111;
    repeat (7) tick();
    check("t3b_rel", btn_prs, 0);

    // Steady-state level table
    for (int v = 0; v < 6; v++) begin
      btn_in = vecs[v].btn;
      sw_in  = vecs[v].sw;
      for (int unsigned t = 0; t < vecs[v].ticks; t++) tick();
      check($sformatf("vec%0d_prs", v), btn_prs, vecs[v].prs);
      check($sformatf("vec%0d_lvl", v), sw_lvl, vecs[v].lvl);
      check($sformatf("vec%0d_sys", v), sys_rst_n, vecs[v].rst);
      check($sformatf("vec%0d_strobes", v), {btn_dn, btn_up, sw_chg}, 0);
    end

    // Two switch bits flipping on the same edge: one sw_chg pulse
    sw_in = 10'h001;
    repeat (8) tick();
    check("t4_pre", sw_lvl, 10'h001);
    sw_in = 10'h002;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("t4_chg", sw_chg, (i == 6));
      check("t4_lvl", sw_lvl, (i >= 6) ? 10'h002 : 10'h001);
    end

    // Reset button held 20 clocks in RUN
    btn_in = 3'b110;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("t5_press", sys_rst_n, (i < 6));
    end
    btn_in = 3'b111;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("t5_rel", sys_rst_n, 0);
    end
    // Now in COUNT; a second press must restart the stretch from zero
    btn_in = 3'b110;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("t5_mid", sys_rst_n, 0);
    end
    btn_in = 3'b111;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("t5_restart", sys_rst_n, (i == 15));
    end

    // Async reset in the middle of a debounce count
    btn_in = 3'b101;
    repeat (4) tick();
    check("t6_pre_lvl", sw_lvl, 10'h002);
    rst_n = 1'b0;
    #1;
    check("t6_prs", btn_prs, 0);
    check("t6_lvl", sw_lvl, 0);
    check("t6_strobes", {btn_dn, btn_up, sw_chg}, 0);
    check("t6_sys", sys_rst_n, 0);
    repeat (3) @(negedge clk);
    btn_in = 3'b111;
    sw_in  = '0;
    rst_n  = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("t6_post_strobes", {btn_dn, btn_up, sw_chg}, 0);
      check("t6_post_prs", btn_prs, 0);
      check("t6_post_sys", sys_rst_n, (i >= 9));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
